hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Multi-cycle sequencer for MIPS mult/multu/div/divu. It owns the HI/LO register pair and replaces the combinational 64-bit multiply/divide path with a radix-2 iterative engine. It sits beside the single-cycle ALU, raises Busy so the control unit can stall mfhi/mflo and new mul/div, and supports mthi/mtlo writes.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH bits split into HI and LO.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
Start  input  1  request a new operation; sampled only when accepted (see Behaviour)
Op  input  2  00 multu, 01 divu, 10 mult, 11 div
SrcA  input  WIDTH  multiplicand or dividend
SrcB  input  WIDTH  multiplier or divisor
WrHi  input  1  mthi strobe
WrLo  input  1  mtlo strobe
WrData  input  WIDTH  data for mthi/mtlo
Busy  output  1  operation in flight
Done  output  1  one-cycle pulse when HI/LO are updated by an operation
DivByZero  output  1  sticky flag, set by a divide with SrcB==0
Hi  output  WIDTH  HI register (product upper half or remainder)
Lo  output  WIDTH  LO register (product lower half or quotient)

Behaviour:
- Reset: on a clk edge with rst_n=0, the state goes to IDLE and Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0. The counter and internal accumulators are cleared. Reset mid-operation aborts the operation, and its result is never written.
- States: IDLE, MUL, DIV.
- Start is accepted only in IDLE, including the cycle Done is high. Start while Busy=1 is ignored and not queued.
- At the accepting edge, latch the operands and go to MUL (Op[0]=0) or DIV (Op[0]=1). The counter loads WIDTH-1.
- Busy=1 for exactly WIDTH cycles after the accepting edge.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- On the edge where the counter is 0:
  - MUL writes {Hi,Lo} = product.
  - DIV writes Lo = quotient and Hi = remainder.
  - State returns to IDLE and Done=1 for one cycle.
- Latency: Start accepted at edge k gives Done high during the cycle after edge k+WIDTH, with Hi/Lo valid in that same cycle.
- Divide by zero (SrcB==0 at acceptance): no iteration. The next edge writes Hi=0, Lo=0, sets DivByZero=1 and pulses Done, so latency is 1 cycle. DivByZero is cleared only by reset.
- mthi/mtlo:
  - WrHi/WrLo write on the next edge, and only in IDLE.
  - They are ignored while Busy=1.
  - If Start is accepted in the same cycle, Start wins and the writes are dropped.
  - WrHi and WrLo together write both registers with WrData.
- Hi/Lo hold their values except at a completion edge, an mthi/mtlo write, or reset.
- Arithmetic is modulo 2^(2*WIDTH). The product is exact, with no overflow detection.

Optional Feature:
SIGNED_MULDIV_EN.
- Defined: Op 10/11 are two's-complement. Operands are converted to magnitudes, the unsigned engine runs, and signs are fixed up at completion: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign. This adds one cycle, so Done comes WIDTH+1 cycles after acceptance.
- Undefined: Op[1] is ignored, all operations are unsigned, and latency is WIDTH.

Decomposition:
- Package muldiv_pkg:
  - Op encodings: OP_MULTU, OP_DIVU, OP_MULT, OP_DIV.
  - State enum: IDLE, MUL, DIV, plus FIX, which exists only under the macro.
  - Default WIDTH.
- Sub-module muldiv_iter_dp: holds the accumulator/remainder registers and the per-cycle shift-add/subtract step. The controller keeps the FSM, counter, HI/LO and handshake.

Test Plan:
1. multu 0xFFFFFFFF * 0xFFFFFFFF -> Done 32 cycles after the accepting edge; Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for exactly 32 cycles.
2. divu 100 / 7 -> Lo=14, Hi=2, Done once. Then divu 5 / 0 -> Done 1 cycle later, Hi=0, Lo=0, DivByZero=1 and still 1 after a later valid op.
3. Start multu 3*4, then Start divu 9/3 at cycle 5 while Busy -> second request ignored; Hi=0, Lo=12. Back-to-back Start in the Done cycle is accepted.
4. mthi 0xDEADBEEF in IDLE -> Hi=0xDEADBEEF next cycle. WrLo while Busy -> Lo unchanged. WrHi together with accepted Start -> write dropped.
5. rst_n=0 at cycle 10 of a multu -> next cycle Busy=0, Done=0, Hi=Lo=0, and no Done ever fires for the aborted op.
6. With SIGNED_MULDIV_EN: div -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF after 33 cycles; mult -3*5 -> {Hi,Lo}=0xFFFFFFFF_FFFFFFF1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and state type for the HI/LO multiply/divide sequencer.
// The FIX state exists only when SIGNED_MULDIV_EN is defined.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

`ifdef SIGNED_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`endif

endpackage

// File: rtl/muldiv_iter_dp.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide, one bit per step.
// o_nxt_* expose the result of the step about to be taken so the controller can capture it.
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_div,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_nxt_hi,
    output logic [WIDTH-1:0] o_nxt_lo
);

    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: r_hi accumulates, r_lo holds the multiplier and fills with product bits.
    // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = WIDTH'(w_shift - {1'b0, r_opnd});

    always_comb begin
        o_nxt_hi = w_sum[WIDTH:1];
        o_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            o_nxt_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_nxt_lo = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_div  <= i_div;
            r_hi   <= '0;
            r_lo   <= i_div ? i_a : i_b;
            r_opnd <= i_div ? i_b : i_a;
        end else if (i_step) begin
            r_hi <= o_nxt_hi;
            r_lo <= o_nxt_lo;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle mult/div sequencer with mthi/mtlo support.
// Optional SIGNED_MULDIV_EN adds signed mult/div via a sign fix-up cycle.
//
// state | meaning
// IDLE  | accepts Start or mthi/mtlo writes
// MUL   | shift-add iterations, result written when counter hits 0
// DIV   | restoring iterations, or a one-cycle divide-by-zero completion
// FIX   | signed result correction (SIGNED_MULDIV_EN only)
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             WrHi,
    input  logic             WrLo,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_step;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_dp_hi;
    logic [WIDTH-1:0] w_dp_lo;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    assign w_accept = (r_state == IDLE) && Start;
    assign w_step   = (r_state == MUL) || ((r_state == DIV) && !r_zero);

`ifdef SIGNED_MULDIV_EN
    logic             r_signed;
    logic             r_op_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_neg_a = Op[1] && SrcA[WIDTH-1];
    assign w_neg_b = Op[1] && SrcB[WIDTH-1];
    assign w_a     = w_neg_a ? -SrcA : SrcA;
    assign w_b     = w_neg_b ? -SrcB : SrcB;

    always_comb begin
        w_fix_hi = w_dp_hi;
        w_fix_lo = w_dp_lo;
        if (r_op_div) begin
            if (r_neg_q) w_fix_lo = -w_dp_lo;
            if (r_neg_r) w_fix_hi = -w_dp_hi;
        end else if (r_neg_q) begin
            {w_fix_hi, w_fix_lo} = -{w_dp_hi, w_dp_lo};
        end
    end
`else
    logic w_unused_sig;

    assign w_a          = SrcA;
    assign w_b          = SrcB;
    assign w_unused_sig = Op[1] ^ (^w_dp_hi) ^ (^w_dp_lo);
`endif

    muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_div    (Op[0]),
        .i_step   (w_step),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_hi     (w_dp_hi),
        .o_lo     (w_dp_lo),
        .o_nxt_hi (w_nxt_hi),
        .o_nxt_lo (w_nxt_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_zero  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef SIGNED_MULDIV_EN
            r_signed <= 1'b0;
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_zero  <= Op[0] && (SrcB == '0);
                        r_state <= Op[0] ? DIV : MUL;
`ifdef SIGNED_MULDIV_EN
                        r_signed <= Op[1];
                        r_op_div <= Op[0];
                        r_neg_q  <= w_neg_a ^ w_neg_b;
                        r_neg_r  <= w_neg_a;
`endif
                    end else begin
                        if (WrHi) r_hi <= WrData;
                        if (WrLo) r_lo <= WrData;
                    end
                end
                MUL, DIV: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_zero) begin
                        r_hi    <= '0;
                        r_lo    <= '0;
                        r_dbz   <= 1'b1;
                        r_zero  <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
`ifdef SIGNED_MULDIV_EN
                        if (r_signed) begin
                            r_state <= FIX;
                        end else begin
                            r_hi    <= w_nxt_hi;
                            r_lo    <= w_nxt_lo;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
`else
                        r_hi    <= w_nxt_hi;
                        r_lo    <= w_nxt_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef SIGNED_MULDIV_EN
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         WrHi = 1'b0;
    logic         WrLo = 1'b0;
    logic [W-1:0] WrData = '0;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Op        (Op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .WrHi      (WrHi),
        .WrLo      (WrLo),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Counts edges since the accepting edge until Done is seen at a negedge.
    task automatic wait_done(output int lat, output int busy_cyc, output bit to);
        lat = 0; busy_cyc = 0; to = 1'b0;
        while (!Done) begin
            if (Busy) busy_cyc++;
            if (lat >= 200) begin to = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
        n_tests++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
        n_tests++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", Hi); end
        n_tests++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", Lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int lat, bc; bit to;
        drive_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc, to);
        n_tests++; if (to || lat != 32) begin n_fail++; $display("FAIL multu_latency: got %0d timeout=%0d want 32", lat, to); end
        n_tests++; if (bc != 32) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 32", bc); end
        n_tests++; if (Hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", Hi); end
        n_tests++; if (Lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", Lo); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b want 0", Busy); end
        @(negedge clk);
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", Done); end
    endtask

    task automatic test_divu();
        int lat, bc; bit to;
        drive_start(2'b01, 32'd100, 32'd7);
        wait_done(lat, bc, to);
        n_tests++; if (to || lat != 32) begin n_fail++; $display("FAIL divu_latency: got %0d timeout=%0d want 32", lat, to); end
        n_tests++; if (Lo !== 32'd14) begin n_fail++; $display("FAIL divu_quot: got %0d want 14", Lo); end
        n_tests++; if (Hi !== 32'd2) begin n_fail++; $display("FAIL divu_rem: got %0d want 2", Hi); end
        n_tests++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL divu_dbz_clear: got %b want 0", DivByZero); end
        @(negedge clk);
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL divu_done_once: got %b want 0", Done); end
        drive_start(2'b01, 32'd5, 32'd0);
        wait_done(lat, bc, to);
        n_tests++; if (to || lat != 1) begin n_fail++; $display("FAIL dbz_latency: got %0d timeout=%0d want 1", lat, to); end
        n_tests++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL dbz_hi: got %h want 0", Hi); end
        n_tests++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL dbz_lo: got %h want 0", Lo); end
        n_tests++; if (DivByZero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", DivByZero); end
        @(negedge clk);
        drive_start(2'b00, 32'd6, 32'd7);
        wait_done(lat, bc, to);
        n_tests++; if (to || Lo !== 32'd42) begin n_fail++; $display("FAIL after_dbz_lo: got %0d timeout=%0d want 42", Lo, to); end
        n_tests++; if (DivByZero !== 1'b1) begin n_fail++; $display("FAIL dbz_sticky: got %b want 1", DivByZero); end
    endtask

    task automatic test_busy_ignore();
        int lat, bc, ndone; bit to;
        @(negedge clk);
        drive_start(2'b00, 32'd3, 32'd4);
        lat = 0; to = 1'b0;
        while (!Done) begin
            if (lat == 5) begin Start = 1'b1; Op = 2'b01; SrcA = 32'd9; SrcB = 32'd3; end
            if (lat == 6) Start = 1'b0;
            if (lat >= 200) begin to = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        n_tests++; if (to || lat != 32) begin n_fail++; $display("FAIL ignore_latency: got %0d timeout=%0d want 32", lat, to); end
        n_tests++; if (Hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %0d want 0", Hi); end
        n_tests++; if (Lo !== 32'd12) begin n_fail++; $display("FAIL ignore_lo: got %0d want 12", Lo); end
        drive_start(2'b00, 32'd5, 32'd5);
        wait_done(lat, bc, to);
        n_tests++; if (to || lat != 32) begin n_fail++; $display("FAIL b2b_latency: got %0d timeout=%0d want 32", lat, to); end
        n_tests++; if (Lo !== 32'd25) begin n_fail++; $display("FAIL b2b_lo: got %0d want 25", Lo); end
        ndone = 0;
        repeat (40) begin @(negedge clk); if (Done) ndone++; end
        n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL no_queued_op: got %0d extra Done want 0", ndone); end
    endtask

    task automatic test_mthi_mtlo();
        int lat, bc; bit to;
        WrHi = 1'b1; WrData = 32'hDEAD_BEEF;
        @(negedge clk);
        WrHi = 1'b0;
        n_tests++; if (Hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mthi: got %h want deadbeef", Hi); end
        n_tests++; if (Lo !== 32'd25) begin n_fail++; $display("FAIL mthi_lo_hold: got %h want 19", Lo); end
        drive_start(2'b00, 32'd2, 32'd3);
        WrLo = 1'b1; WrData = 32'h0000_1234;
        @(negedge clk);
        WrLo = 1'b0;
        n_tests++; if (Lo !== 32'd25) begin n_fail++; $display("FAIL mtlo_busy: got %h want 19", Lo); end
        wait_done(lat, bc, to);
        n_tests++; if (to || Lo !== 32'd6 || Hi !== 32'd0) begin n_fail++; $display("FAIL mul_2x3: got %h_%h timeout=%0d want 0_6", Hi, Lo, to); end
        WrHi = 1'b1; WrData = 32'hAAAA_5555;
        drive_start(2'b00, 32'd1, 32'd1);
        WrHi = 1'b0;
        n_tests++; if (Hi !== 32'd0) begin n_fail++; $display("FAIL mthi_vs_start: got %h want 0", Hi); end
        wait_done(lat, bc, to);
        n_tests++; if (to || Lo !== 32'd1 || Hi !== 32'd0) begin n_fail++; $display("FAIL mul_1x1: got %h_%h timeout=%0d want 0_1", Hi, Lo, to); end
        @(negedge clk);
        WrHi = 1'b1; WrLo = 1'b1; WrData = 32'h1357_2468;
        @(negedge clk);
        WrHi = 1'b0; WrLo = 1'b0;
        n_tests++; if (Hi !== 32'h1357_2468 || Lo !== 32'h1357_2468) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h_%h want 13572468_13572468", Hi, Lo); end
    endtask

    task automatic test_op_high_bit();
        int lat, bc; bit to;
        drive_start(2'b10, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat, bc, to);
`ifdef SIGNED_MULDIV_EN
        n_tests++; if (to || lat != 33) begin n_fail++; $display("FAIL mult_latency: got %0d timeout=%0d want 33", lat, to); end
        n_tests++; if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_m1x2: got %h_%h want ffffffff_fffffffe", Hi, Lo); end
`else
        n_tests++; if (to || lat != 32) begin n_fail++; $display("FAIL op10_latency: got %0d timeout=%0d want 32", lat, to); end
        n_tests++; if (Hi !== 32'h0000_0001 || Lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL op10_unsigned: got %h_%h want 00000001_fffffffe", Hi, Lo); end
`endif
    endtask

`ifdef SIGNED_MULDIV_EN
    task automatic test_signed();
        int lat, bc; bit to;
        @(negedge clk);
        drive_start(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc, to);
        n_tests++; if (to || lat != 33) begin n_fail++; $display("FAIL div_latency: got %0d timeout=%0d want 33", lat, to); end
        n_tests++; if (Lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_quot: got %h want fffffffd", Lo); end
        n_tests++; if (Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_rem: got %h want ffffffff", Hi); end
        @(negedge clk);
        drive_start(2'b10, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bc, to);
        n_tests++; if (to || Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_m3x5: got %h_%h timeout=%0d want ffffffff_fffffff1", Hi, Lo, to); end
    endtask
`endif

    task automatic test_reset_abort();
        int ndone;
        @(negedge clk);
        drive_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", Busy); end
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", Done); end
        n_tests++; if (Hi !== 32'h0 || Lo !== 32'h0) begin n_fail++; $display("FAIL abort_hilo: got %h_%h want 0_0", Hi, Lo); end
        n_tests++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL abort_dbz: got %b want 0", DivByZero); end
        rst_n = 1'b1;
        ndone = 0;
        repeat (60) begin @(negedge clk); if (Done) ndone++; end
        n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d Done want 0", ndone); end
        n_tests++; if (Hi !== 32'h0 || Lo !== 32'h0) begin n_fail++; $display("FAIL abort_hilo_hold: got %h_%h want 0_0", Hi, Lo); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_multu_max();
        test_divu();
        test_busy_ignore();
        test_mthi_mtlo();
        @(negedge clk);
        test_op_high_bit();
`ifdef SIGNED_MULDIV_EN
        test_signed();
`endif
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
